button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream stage of the whack-a-mole game controller. Conditions the raw, asynchronous, active-low push buttons before the game logic sees them: the four mole buttons and the start button.
- Per channel it synchronises the input, debounces it with a stable-time counter, and produces a clean level plus single-cycle press and release pulses.
- The game logic consumes press_pulse directly and drops its own raw edge detection.

Parameters:
- NUM_BTN, 5, number of button channels (index 0..3 = mole buttons, 4 = start).
- SYNC_STAGES, 2, flip-flop synchroniser depth; minimum 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (10 ms at 100 MHz); minimum 1.
- REPEAT_DELAY, 50000000, cycles held before the first auto-repeat pulse (only used with the optional feature).
- REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses (only used with the optional feature).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- btn_n  input  NUM_BTN  raw button pins, active-low (0 = pressed), asynchronous to clk.
- btn_level  output  NUM_BTN  debounced state, 1 = pressed.
- press_pulse  output  NUM_BTN  one-cycle pulse on each accepted press.
- release_pulse  output  NUM_BTN  one-cycle pulse on each accepted release.

Behaviour:
- All channels are identical and independent. There is no cross-channel interaction, so simultaneous presses on any subset of channels each produce their own pulses in the same cycle.
- Reset (reset == 0, asynchronous):
  - All synchroniser flops are set to 1 (released).
  - All channel FSMs go to UP and all counters clear.
  - btn_level, press_pulse and release_pulse are all 0.
  - A button held down through reset deassertion is therefore treated as a fresh press after full debounce. There are no spurious pulses at reset release.
- Synchroniser: s = btn_n after SYNC_STAGES flops. All FSM decisions use s only.
- Per-channel FSM, states UP, WAIT_DOWN, DOWN, WAIT_UP, with counter cnt of width clog2(DEBOUNCE_CYCLES+1):
  - UP: s == 0 -> WAIT_DOWN, cnt <= 0.
  - WAIT_DOWN: s == 1 -> UP (glitch rejected, no pulse). Else if cnt == DEBOUNCE_CYCLES-1 -> DOWN, btn_level <= 1, press_pulse <= 1 for one cycle. Else cnt <= cnt+1.
  - DOWN: s == 1 -> WAIT_UP, cnt <= 0.
  - WAIT_UP: s == 0 -> DOWN (no pulse). Else if cnt == DEBOUNCE_CYCLES-1 -> UP, btn_level <= 0, release_pulse <= 1 for one cycle. Else cnt <= cnt+1.
- Latency: if btn_n falls and is sampled low at edge k and stays stable, press_pulse is high in the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES. Release latency is the same.
- All outputs are registered. press_pulse and release_pulse are never high in consecutive cycles for the same channel, except auto-repeat when enabled (see below).
- Any bounce shorter than DEBOUNCE_CYCLES restarts the wait, via the UP/DOWN return. Continuous bouncing yields no pulse at all.
- Mid-operation reset: the current state is lost immediately and the rules above apply on release.

Optional Feature:
- Macro: BTN_CONDITIONER_REPEAT_EN.
- Defined:
  - Each channel has an extra repeat counter that clears on entry to DOWN.
  - While in DOWN, after REPEAT_DELAY cycles an extra press_pulse is emitted, then one every REPEAT_PERIOD cycles.
  - Leaving DOWN (to WAIT_UP) stops repeats; returning from WAIT_UP to DOWN restarts REPEAT_DELAY.
- Undefined: no repeat logic is synthesised; exactly one press_pulse per accepted press.

Decomposition:
- Shared package button_pkg:
  - FSM state enum: UP, WAIT_DOWN, DOWN, WAIT_UP.
  - Default constants: CLK_HZ = 100000000, default debounce cycles, button index constants (BTN_MOLE0..BTN_MOLE3, BTN_START).
- Sub-module button_debounce_ch: one channel (synchroniser, FSM, counters, optional repeat).
- Top level is a generate loop of NUM_BTN instances.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset held low with btn_n=5'b00000, released at edge 0, inputs held -> all outputs 0 until press_pulse=5'b11111 in the cycle after edge 6; btn_level=5'b11111 from then on.
- btn_n[0] falls at edge 10 and stays low -> press_pulse[0] high only in the cycle after edge 16, btn_level[0]=1. Raise at edge 30 -> release_pulse[0] high in the cycle after edge 36.
- btn_n[1] low for 3 cycles, high for 1, repeated 10 times -> press_pulse[1] and btn_level[1] stay 0 throughout.
- btn_n[2] and btn_n[4] fall at the same edge -> press_pulse = 5'b10100 for exactly one cycle.
- Reset asserted 2 cycles into WAIT_DOWN on btn 3 -> outputs go 0 asynchronously. After release with btn_n[3] still low, press_pulse[3] follows a full 6 cycles later.
- With BTN_CONDITIONER_REPEAT_EN, btn 0 held 25 cycles after acceptance -> press_pulse[0] at acceptance, then at +10, +13, +16, +19, +22. Without the macro -> a single pulse.

Source files
------------

// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button conditioning path of the
// whack-a-mole controller.
//   btn_state_e              : per-channel debounce FSM state
//   CLK_HZ                   : system clock frequency
//   DEFAULT_* constants      : default channel count / timing in clock cycles
//   BTN_MOLE0..3, BTN_START  : bit positions of each button in the bus
// ---------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } btn_state_e;

    localparam int CLK_HZ                  = 100000000;
    localparam int DEBOUNCE_MS             = 10;
    localparam int DEFAULT_NUM_BTN         = 5;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEFAULT_REPEAT_DELAY    = 50000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

    localparam int BTN_MOLE0 = 0;
    localparam int BTN_MOLE1 = 1;
    localparam int BTN_MOLE2 = 2;
    localparam int BTN_MOLE3 = 3;
    localparam int BTN_START = 4;

endpackage

// File: rtl/button_debounce_ch.sv
// ---------------------------------------------------------------------------
// button_debounce_ch
// One button channel: synchroniser, debounce FSM with stable-time counter,
// registered level and single-cycle press/release pulses.
// Optional auto-repeat of press_pulse while held: define
// BTN_CONDITIONER_REPEAT_EN.
// Ports:
//   clk           : system clock
//   reset         : asynchronous reset, active low
//   btn_n         : raw button pin, active low, asynchronous to clk
//   btn_level     : debounced state, 1 = pressed
//   press_pulse   : one-cycle pulse per accepted press (plus repeats)
//   release_pulse : one-cycle pulse per accepted release
// The FSM state is held in the signal 'state' for hierarchical observation.
// ---------------------------------------------------------------------------
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchroniser resets to all ones so the channel starts "released".
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    btn_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_next, press_next, release_next;
    logic             repeat_fire;

    assign s = sync_q[SYNC_STAGES-1];

    // State register, counters, synchroniser and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q        <= '1;
            state         <= UP;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], btn_n};
            state         <= state_next;
            cnt           <= cnt_next;
            btn_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
        end
    end

    // Next-state logic. A bounce back to the old level returns to UP/DOWN,
    // so the stable-time count restarts from zero on the next attempt.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            UP: begin
                if (!s) begin
                    state_next = WAIT_DOWN;
                    cnt_next   = '0;
                end
            end
            WAIT_DOWN: begin
                if (s) begin
                    state_next = UP;
                end else if (cnt == CNT_LAST) begin
                    state_next = DOWN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DOWN: begin
                if (s) begin
                    state_next = WAIT_UP;
                    cnt_next   = '0;
                end
            end
            WAIT_UP: begin
                if (!s) begin
                    state_next = DOWN;
                end else if (cnt == CNT_LAST) begin
                    state_next = UP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = UP;
        endcase
    end

    // Output logic: values loaded into the output registers on this edge.
    always_comb begin
        level_next   = (state_next == DOWN) || (state_next == WAIT_UP);
        press_next   = ((state == WAIT_DOWN) && (state_next == DOWN)) || repeat_fire;
        release_next = (state == WAIT_UP) && (state_next == UP);
    end

`ifdef BTN_CONDITIONER_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rcnt, rcnt_next;
    logic             rfirst, rfirst_next;   // 1 while waiting for the first repeat

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
        end else begin
            rcnt   <= rcnt_next;
            rfirst <= rfirst_next;
        end
    end

    // Any entry into DOWN (fresh press or return from WAIT_UP) restarts the
    // initial delay; counting only advances while DOWN is held.
    always_comb begin
        rcnt_next   = rcnt;
        rfirst_next = rfirst;
        repeat_fire = 1'b0;
        if ((state_next == DOWN) && (state != DOWN)) begin
            rcnt_next   = '0;
            rfirst_next = 1'b1;
        end else if ((state == DOWN) && (state_next == DOWN)) begin
            if (rcnt == (rfirst ? DELAY_LAST : PERIOD_LAST)) begin
                repeat_fire = 1'b1;
                rcnt_next   = '0;
                rfirst_next = 1'b0;
            end else begin
                rcnt_next = rcnt + 1'b1;
            end
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions the raw active-low buttons (four moles + start) of the
// whack-a-mole controller: one independent debounce channel per button.
// Optional auto-repeat of press_pulse: define BTN_CONDITIONER_REPEAT_EN.
// Ports:
//   clk           : system clock, 100 MHz
//   reset         : asynchronous reset, active low
//   btn_n         : raw button pins, active low (0 = pressed)
//   btn_level     : debounced state per button, 1 = pressed
//   press_pulse   : one-cycle pulse per accepted press
//   release_pulse : one-cycle pulse per accepted release
// ---------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = DEFAULT_NUM_BTN,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .btn_n        (btn_n[i]),
            .btn_level    (btn_level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Inputs change on the falling edge so that "edge e" below is the first
// rising edge that samples a new value; outputs are sampled on the falling
// edge after each rising edge. Expected press latency is edge 6.
// Honours BTN_CONDITIONER_REPEAT_EN for the auto-repeat expectations.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_n;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    button_conditioner #(
        .NUM_BTN        (NB),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_n        (btn_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [NB-1:0] got,
                            input logic [NB-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic check_outs(input string tag, input logic [NB-1:0] ep,
                              input logic [NB-1:0] er, input logic [NB-1:0] el);
        check_eq({tag, " press"},   press_pulse,   ep);
        check_eq({tag, " release"}, release_pulse, er);
        check_eq({tag, " level"},   btn_level,     el);
    endtask

    // Advance one rising edge and check outputs on the following falling edge.
    task automatic step_check(input string tag, input logic [NB-1:0] ep,
                              input logic [NB-1:0] er, input logic [NB-1:0] el);
        @(posedge clk);
        @(negedge clk);
        check_outs(tag, ep, er, el);
    endtask

    // Press 'mask' (others released) and check the 9 cycles after edge 0..8.
    task automatic press_seq(input string tag, input logic [NB-1:0] mask,
                             input logic [NB-1:0] held);
        btn_n = ~(mask | held);
        for (int e = 0; e <= 8; e++)
            step_check($sformatf("%s e%0d", tag, e),
                       (e == 6) ? mask : '0, '0,
                       held | ((e >= 6) ? mask : '0));
    endtask

    // Release everything and check the release of 'mask'.
    task automatic release_seq(input string tag, input logic [NB-1:0] mask);
        btn_n = '1;
        for (int e = 0; e <= 8; e++)
            step_check($sformatf("%s e%0d", tag, e),
                       '0, (e == 6) ? mask : '0, (e < 6) ? mask : '0);
    endtask

    // Expected press pulse on btn 0 while held, e = edges since the fall.
    function automatic logic rep_exp(input int e);
        if (e == 6) return 1'b1;
`ifdef BTN_CONDITIONER_REPEAT_EN
        if (e >= 16 && ((e - 16) % 3) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        btn_n = '0;
        repeat (3) @(negedge clk);
        check_outs("in_reset", '0, '0, '0);

        // Buttons held through reset release: fresh press after full debounce.
        reset = 1'b1;
        for (int e = 0; e <= 8; e++)
            step_check($sformatf("held_rst e%0d", e),
                       (e == 6) ? 5'b11111 : 5'b00000, 5'b00000,
                       (e >= 6) ? 5'b11111 : 5'b00000);
        release_seq("rel_all", 5'b11111);
        for (int i = 0; i < 3; i++) step_check("idle", '0, '0, '0);

        // Single clean press and release on mole 0.
        press_seq("press0", 5'b00001, '0);
        release_seq("release0", 5'b00001);

        // Bouncing mole 1: 3 low / 1 high, ten times, must never be accepted.
        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < 4; j++) begin
                btn_n = (j < 3) ? 5'b11101 : 5'b11111;
                step_check($sformatf("bounce r%0d j%0d", r, j), '0, '0, '0);
            end
        end
        btn_n = '1;
        for (int i = 0; i < 6; i++) step_check("bounce_tail", '0, '0, '0);

        // Simultaneous mole 2 and start.
        press_seq("press24", 5'b10100, '0);
        release_seq("release24", 5'b10100);

        // Mid-operation reset: mole 0 accepted, mole 3 in WAIT_DOWN.
        press_seq("pre0", 5'b00001, '0);
        btn_n = 5'b10110;
        for (int e = 0; e <= 3; e++)
            step_check($sformatf("wd3 e%0d", e), '0, '0, 5'b00001);
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_rst", '0, '0, '0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_outs("rst_hold", '0, '0, '0);
        end
        reset = 1'b1;
        press_seq("after_rst", 5'b01001, '0);
        release_seq("after_rst_rel", 5'b01001);

        // Long hold on mole 0: single pulse, or auto-repeat when enabled.
        btn_n = 5'b11110;
        for (int e = 0; e <= 27; e++)
            step_check($sformatf("hold e%0d", e),
                       rep_exp(e) ? 5'b00001 : 5'b00000, '0,
                       (e >= 6) ? 5'b00001 : 5'b00000);
        // Edge 28 is still seen as held by the FSM (synchroniser delay).
        btn_n = '1;
        for (int e = 0; e <= 8; e++)
            step_check($sformatf("hold_rel e%0d", e),
                       ((e == 0) && rep_exp(28)) ? 5'b00001 : 5'b00000,
                       (e == 6) ? 5'b00001 : 5'b00000,
                       (e < 6) ? 5'b00001 : 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
